// File: rtl/decim_pkg.sv
// decim_pkg: shared constants and types for the decimated-sample serializer
package decim_pkg;
    localparam int DEFAULT_DATA_BITS = 16;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} ser_state_t;
    typedef logic [DEFAULT_DATA_BITS-1:0] sample_t;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous FIFO with async reset; push is accepted when full if a pop happens in the same cycle
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full = count == (AW + 1)'(DEPTH);
    assign empty = count == '0;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
            count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end
endmodule

// File: rtl/decim_sample_serializer.sv
// decim_sample_serializer: buffers decimated samples and ships them MSB-first over a frame_n/sclk_out/sdo link
module decim_sample_serializer
    import decim_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          sample_in,
    input  logic                          sample_valid,
    input  logic                          clr_overflow,
    output logic                          frame_n,
    output logic                          sclk_out,
    output logic                          sdo,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int BW = $clog2(DATA_BITS);
    localparam int CW = $clog2(2 * CLK_DIV);
    ser_state_t state;
    logic [DATA_BITS-1:0] head, shreg;
    logic [BW-1:0] bit_cnt;
    logic [CW-1:0] cnt;
    logic full, empty, pop, drop;
    assign pop = state == LOAD;
    assign drop = sample_valid && full && !pop;
    sample_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (sample_valid),
        .pop   (pop),
        .din   (sample_in),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) overflow <= 1'b0;
        else overflow <= drop || (overflow && !clr_overflow);
    end
    // cnt paces sclk half-periods in SHIFT and times the inter-frame gap in GAP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            frame_n <= 1'b1;
            sclk_out <= 1'b0;
            sdo <= 1'b0;
            shreg <= '0;
            bit_cnt <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    bit_cnt <= '0;
                    if (!empty) state <= LOAD;
                end
                LOAD: begin
                    shreg <= head;
                    sdo <= head[DATA_BITS-1];
                    frame_n <= 1'b0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    if (cnt != CW'(CLK_DIV - 1)) cnt <= cnt + 1'b1;
                    else begin
                        cnt <= '0;
                        sclk_out <= !sclk_out;
                        if (sclk_out && bit_cnt == BW'(DATA_BITS - 1)) begin
                            frame_n <= 1'b1;
                            sdo <= 1'b0;
                            state <= GAP;
                        end else if (sclk_out) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg <= shreg << 1;
                            sdo <= shreg[DATA_BITS-2];
                        end
                    end
                end
                GAP: begin
                    cnt <= cnt == CW'(2 * CLK_DIV - 1) ? '0 : cnt + 1'b1;
                    if (cnt == CW'(2 * CLK_DIV - 1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_decim_sample_serializer.sv
// tb_decim_sample_serializer: randomized and directed checks against a queue-based frame-timing model
module tb_decim_sample_serializer;
    localparam int DATA_BITS = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int CLK_DIV = 2;
    localparam int FRAME_LOW = DATA_BITS * 2 * CLK_DIV;
    localparam int FRAME_BUSY = FRAME_LOW + 2 * CLK_DIV;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [15:0] sample_in = '0;
    logic sample_valid = 1'b0;
    logic clr_overflow = 1'b0;
    logic frame_n, sclk_out, sdo, overflow;
    logic [2:0] fifo_count;
    logic [15:0] sample_in2 = 16'hFFFF;
    logic sample_valid2 = 1'b0;
    logic frame_n2, sclk_out2, sdo2, overflow2;
    logic [2:0] fifo_count2;

    int checks = 0;
    int errors = 0;

    logic [15:0] q[$];
    logic [15:0] exp_q[$];
    int busy = 0;
    logic pop_pending = 1'b0;
    logic movf = 1'b0;

    int low_cnt = 0, rises = 0, frames = 0, peak = 0;
    logic [15:0] bits = '0, last_word = '0;
    logic prev_frame = 1'b1, prev_sclk = 1'b0;
    int low2 = 0, rises2 = 0, frames2 = 0, high2 = 0;
    logic [15:0] bits2 = '0;
    logic prev_frame2 = 1'b1, prev_sclk2 = 1'b0;

    always #5 clk = ~clk;

    decim_sample_serializer #(.DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .clr_overflow(clr_overflow), .frame_n(frame_n), .sclk_out(sclk_out), .sdo(sdo),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    decim_sample_serializer #(.DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH), .CLK_DIV(1)) dut2 (
        .clk(clk), .reset(reset), .sample_in(sample_in2), .sample_valid(sample_valid2),
        .clr_overflow(1'b0), .frame_n(frame_n2), .sclk_out(sclk_out2), .sdo(sdo2),
        .fifo_count(fifo_count2), .overflow(overflow2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_q.delete();
        busy = 0;
        pop_pending = 1'b0;
        movf = 1'b0;
        low_cnt = 0;
        rises = 0;
        prev_frame = 1'b1;
        prev_sclk = 1'b0;
        low2 = 0;
        rises2 = 0;
        high2 = 0;
        prev_frame2 = 1'b1;
        prev_sclk2 = 1'b0;
    endtask

    // One clock: update the model at the rising edge, then check the DUT on the falling edge.
    task automatic tick();
        int sz;
        logic pop, drop;
        logic [15:0] want;
        @(posedge clk);
        if (reset) model_reset();
        else begin
            sz = q.size();
            pop = pop_pending;
            drop = sample_valid && sz == FIFO_DEPTH && !pop;
            if (pop) exp_q.push_back(q.pop_front());
            if (sample_valid && !drop) q.push_back(sample_in);
            movf = drop ? 1'b1 : clr_overflow ? 1'b0 : movf;
            if (pop) begin
                pop_pending = 1'b0;
                busy = FRAME_BUSY;
            end else if (busy > 0) busy--;
            else if (sz != 0) pop_pending = 1'b1;
        end
        @(negedge clk);
        sample_valid = 1'b0;
        clr_overflow = 1'b0;
        sample_valid2 = 1'b0;
        check("fifo_count", 32'(fifo_count), q.size());
        check("overflow", 32'(overflow), 32'(movf));
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
        if (!frame_n) low_cnt++;
        if (sclk_out && !prev_sclk) begin
            bits = {bits[14:0], sdo};
            rises++;
        end
        if (frame_n && !prev_frame) begin
            check("frame_rises", rises, DATA_BITS);
            check("frame_low_len", low_cnt, FRAME_LOW);
            check("frame_expected", 32'(exp_q.size() != 0), 1);
            want = exp_q.size() != 0 ? exp_q.pop_front() : 16'hxxxx;
            check("frame_data", 32'(bits), 32'(want));
            last_word = bits;
            frames++;
            low_cnt = 0;
            rises = 0;
        end
        prev_sclk = sclk_out;
        prev_frame = frame_n;
        if (!frame_n2) low2++;
        if (frame_n2) high2 = prev_frame2 ? high2 + 1 : 1;
        if (!frame_n2 && !prev_frame2) check("sclk2_toggle", 32'(sclk_out2 != prev_sclk2), 1);
        if (!frame_n2 && prev_frame2 && frames2 > 0) check("gap2_len", high2, 4);
        if (sclk_out2 && !prev_sclk2) begin
            bits2 = {bits2[14:0], sdo2};
            rises2++;
        end
        if (frame_n2 && !prev_frame2) begin
            check("frame2_rises", rises2, DATA_BITS);
            check("frame2_low_len", low2, DATA_BITS * 2);
            check("frame2_data", 32'(bits2), 32'h0000FFFF);
            frames2++;
            low2 = 0;
            rises2 = 0;
        end
        prev_sclk2 = sclk_out2;
        prev_frame2 = frame_n2;
    endtask

    task automatic drain(input int limit);
        int i;
        for (i = 0; i < limit && !(q.size() == 0 && exp_q.size() == 0 && busy == 0 && !pop_pending); i++) tick();
        check("drain_in_time", 32'(i < limit), 1);
    endtask

    initial begin
        int i, f0;
        tick();
        tick();
        check("rst_frame_n", 32'(frame_n), 1);
        check("rst_sclk", 32'(sclk_out), 0);
        check("rst_sdo", 32'(sdo), 0);
        reset = 1'b0;
        tick();
        // single word: frame_n falls two edges after the write
        sample_in = 16'hA5C3;
        sample_valid = 1'b1;
        tick();
        check("latency_t0", 32'(frame_n), 1);
        tick();
        check("latency_t1", 32'(frame_n), 1);
        tick();
        check("latency_t2", 32'(frame_n), 0);
        drain(200);
        check("a5c3_word", 32'(last_word), 32'h0000A5C3);
        // five strobes every other cycle: no loss, FIFO fills to 4
        peak = 0;
        f0 = frames;
        for (int k = 1; k <= 5; k++) begin
            sample_in = 16'(k);
            sample_valid = 1'b1;
            tick();
            tick();
        end
        drain(600);
        check("five_frames", frames - f0, 5);
        check("five_peak", peak, 4);
        check("five_overflow", 32'(overflow), 0);
        // six back-to-back strobes while a frame is in flight
        sample_in = 16'h1111;
        sample_valid = 1'b1;
        tick();
        repeat (10) tick();
        for (int k = 0; k < 6; k++) begin
            sample_in = 16'h2000 + 16'(k);
            sample_valid = 1'b1;
            tick();
        end
        check("burst_overflow", 32'(overflow), 1);
        check("burst_count", 32'(fifo_count), 4);
        clr_overflow = 1'b1;
        tick();
        check("overflow_cleared", 32'(overflow), 0);
        // write into a full FIFO during the LOAD cycle
        for (i = 0; i < 200 && !pop_pending; i++) tick();
        check("load_reached", 32'(i < 200), 1);
        sample_in = 16'hBEEF;
        sample_valid = 1'b1;
        tick();
        check("load_write_count", 32'(fifo_count), 4);
        check("load_write_ovf", 32'(overflow), 0);
        // async reset in the middle of bit 7
        for (i = 0; i < 200 && rises < 8; i++) tick();
        check("bit7_reached", 32'(i < 200), 1);
        #1;
        reset = 1'b1;
        #1;
        check("async_frame_n", 32'(frame_n), 1);
        check("async_sclk", 32'(sclk_out), 0);
        check("async_sdo", 32'(sdo), 0);
        check("async_count", 32'(fifo_count), 0);
        check("async_ovf", 32'(overflow), 0);
        model_reset();
        tick();
        reset = 1'b0;
        tick();
        f0 = frames;
        sample_in = 16'h1234;
        sample_valid = 1'b1;
        tick();
        drain(200);
        check("post_reset_frames", frames - f0, 1);
        check("post_reset_word", 32'(last_word), 32'h00001234);
        // CLK_DIV=1 instance: two 16'hFFFF words back to back
        sample_valid2 = 1'b1;
        tick();
        sample_valid2 = 1'b1;
        tick();
        for (i = 0; i < 200 && frames2 < 2; i++) tick();
        check("div1_frames", frames2, 2);
        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            sample_in = 16'($urandom);
            sample_valid = $urandom_range(0, 39) == 0;
            clr_overflow = $urandom_range(0, 49) == 0;
            tick();
        end
        drain(800);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
